imem_rd_port: RTL and testbench
===============================

Name: imem_rd_port

Overview:
- Responder side of the instruction-fetch memory read interface.
- Accepts a read request (m_re, addr, m_rlen) from the fetch stage and reads 1–4 bytes from an internal byte-wide instruction store, one byte per cycle.
- Assembles the bytes little-endian and returns them on m_rdata with m_rack, using a 4-phase request/acknowledge handshake.
- A byte-wide load port preloads the store, e.g. from a testbench or boot loader, before and during execution.

Parameters:
- DATA_L, 32, width of m_rdata; must be 32.
- MADDR_L, 32, width of the request address.
- MEM_AW, 13, log2 of store size in bytes (8 KiB, covers 0x0000–0x1FFF).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- m_re  in  1  read request; level held by the requester until m_rack is seen.
- addr  in  MADDR_L  byte address of first byte; sampled only at request accept.
- m_rlen  in  2  byte count minus 1 (0→1 byte … 3→4 bytes); sampled at accept.
- m_rack  out  1  read acknowledge; high while m_rdata/m_rerr are valid.
- m_rdata  out  DATA_L  assembled read data; byte k in bits [8k+7:8k].
- m_rerr  out  1  address out of range; valid with m_rack.
- busy  out  1  high in RD and ACK states.
- ld_we  in  1  load-port byte write enable.
- ld_addr  in  MEM_AW  load-port byte address.
- ld_data  in  8  load-port byte data.

Behaviour:
- Reset values: m_rack=0, m_rdata=0, m_rerr=0, busy=0, state=IDLE, byte counter=0. Store contents are not reset.
- Store: 2^MEM_AW x 8 array. Combinational read of mem[base+cnt]. Synchronous write on ld_we.
- FSM states: IDLE, RD, ACK.
- IDLE:
  - m_re=1 at an edge → latch base=addr[MEM_AW-1:0], len=m_rlen, oor=|addr[MADDR_L-1:MEM_AW].
  - Same edge: clear m_rdata and m_rerr, set cnt=0, go to RD, busy=1.
  - m_re=0 → stay in IDLE.
- RD:
  - Each edge captures byte mem[(base+cnt) mod 2^MEM_AW] into m_rdata[8cnt+7:8cnt], or 0x00 if oor, then increments cnt.
  - When cnt==len at the edge, that edge also sets m_rack=1, sets m_rerr=oor, and moves to ACK.
  - Unused upper bytes stay 0.
- Latency: m_rack rises exactly len+1 edges after the accepting edge (4 edges for a word).
- ACK:
  - m_rack, m_rdata and m_rerr are held stable while m_re=1.
  - The first edge with m_re=0 clears m_rack and m_rerr, returns to IDLE, and sets busy=0. m_rdata holds its value.
  - A new request can be accepted no earlier than the next edge after that.
- Abort: m_re=0 during RD → next edge returns to IDLE with m_rack never asserted. m_rdata content is then undefined-but-stable.
- Address wrap: base+cnt wraps modulo 2^MEM_AW. A read at 0x1FFE, len=3 returns bytes 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Out of range: any nonzero addr bit at or above MEM_AW sets oor. The read still takes len+1 cycles and returns data 0 with m_rerr=1. The store is not accessed.
- Load/read collision: the load port is always accepted, including while busy. If ld_we targets the byte being captured at the same edge, the captured value is the pre-write value and the store holds the new value afterwards.
- Reset mid-operation: rst has priority in every state. It forces IDLE and the reset output values at that edge.
- m_rlen and addr changes after accept have no effect.

Test Plan:
- Load 0x13,0x05,0x10,0x00 at 0x1000..0x1003; request addr=0x1000, rlen=3 → m_rack rises 4 edges after accept; m_rdata=0x00100513; m_rerr=0.
- Hold m_re for 5 extra cycles, then drop → m_rack and m_rdata stable throughout; m_rack=0 one edge after m_re falls; busy=0.
- rlen=0 at 0x1001 (byte 0x05) → m_rack after 1 edge; m_rdata=0x00000005.
- rlen=3 at 0x1FFE with bytes AA,BB at 0x1FFE/F and CC,DD at 0x0/0x1 → m_rdata=0xDDCCBBAA.
- addr=0x00010000, rlen=3 → m_rack after 4 edges; m_rdata=0; m_rerr=1.
- Abort and reset: drop m_re after 2 RD edges → IDLE, no m_rack. Assert rst during ACK → m_rack=0, busy=0 next edge. Issue a ld_we to byte 2 during its capture edge → old byte returned; a re-read returns the new byte.

Source files
------------

// File: rtl/imem_rd_port_if.sv
// Instruction-fetch read bus: requester drives m_re/addr/m_rlen, responder
// returns m_rack/m_rdata/m_rerr using a 4-phase request/acknowledge handshake.
interface imem_rd_port_if #(
    parameter int unsigned DATA_L  = 32,
    parameter int unsigned MADDR_L = 32
);
    logic               m_re;
    logic [MADDR_L-1:0] addr;
    logic [1:0]         m_rlen;
    logic               m_rack;
    logic [DATA_L-1:0]  m_rdata;
    logic               m_rerr;
    logic               busy;

    modport master (
        output m_re, addr, m_rlen,
        input  m_rack, m_rdata, m_rerr, busy
    );

    modport slave (
        input  m_re, addr, m_rlen,
        output m_rack, m_rdata, m_rerr, busy
    );
endinterface

// File: rtl/imem_rd_port.sv
// Instruction-store read responder: fetches 1-4 bytes one per cycle from a
// byte-wide store and returns them little-endian; a load port preloads the store.
module imem_rd_port #(
    parameter int unsigned DATA_L  = 32,
    parameter int unsigned MADDR_L = 32,
    parameter int unsigned MEM_AW  = 13
) (
    input  logic              clk,
    input  logic              rst,
    imem_rd_port_if.slave     bus,
    input  logic              ld_we,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data
);

    typedef enum logic [1:0] {StIdle, StRd, StAck} state_e;

    state_e             state_q, state_d;
    logic [MEM_AW-1:0]  base_q, base_d;
    logic [1:0]         len_q, len_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               oor_q, oor_d;
    logic [DATA_L-1:0]  rdata_q, rdata_d;
    logic               rack_q, rack_d;
    logic               rerr_q, rerr_d;

    logic [7:0]         mem [0:(1 << MEM_AW) - 1];
    logic [MEM_AW-1:0]  rd_addr;
    logic [7:0]         rd_byte;

    // Address arithmetic wraps naturally at the store size.
    assign rd_addr = base_q + MEM_AW'(cnt_q);
    assign rd_byte = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        rack_d  = rack_q;
        rerr_d  = rerr_q;

        case (state_q)
            StIdle: begin
                if (bus.m_re) begin
                    base_d  = bus.addr[MEM_AW-1:0];
                    len_d   = bus.m_rlen;
                    oor_d   = |bus.addr[MADDR_L-1:MEM_AW];
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = StRd;
                end
            end
            StRd: begin
                if (!bus.m_re) begin
                    // Requester withdrew: abandon without acknowledging.
                    state_d = StIdle;
                end else begin
                    rdata_d[{cnt_q, 3'b000} +: 8] = oor_q ? 8'h00 : rd_byte;
                    if (cnt_q == len_q) begin
                        rack_d  = 1'b1;
                        rerr_d  = oor_q;
                        state_d = StAck;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            StAck: begin
                if (!bus.m_re) begin
                    rack_d  = 1'b0;
                    rerr_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            len_q   <= 2'd0;
            cnt_q   <= 2'd0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            rack_q  <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            rack_q  <= rack_d;
            rerr_q  <= rerr_d;
        end
    end

    assign bus.m_rack  = rack_q;
    assign bus.m_rdata = rdata_q;
    assign bus.m_rerr  = rerr_q;
    assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_imem_rd_port.sv
// Bench for imem_rd_port: table-driven reads scored through an expected-result
// queue, plus hand-written abort, reset-in-ACK and load/read collision sequences.
module tb_imem_rd_port;

    logic        clk;
    logic        rst;
    logic        ld_we;
    logic [12:0] ld_addr;
    logic [7:0]  ld_data;

    int checks = 0;
    int errors = 0;

    imem_rd_port_if #(.DATA_L(32), .MADDR_L(32)) bus ();

    imem_rd_port #(
        .DATA_L (32),
        .MADDR_L(32),
        .MEM_AW (13)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .ld_we  (ld_we),
        .ld_addr(ld_addr),
        .ld_data(ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  rlen;
        logic [31:0] exp_data;
        logic        exp_err;
        int          hold;
    } rec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    rec_t vec[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic ld_byte(input logic [12:0] a, input logic [7:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_we   = 1'b0;
    endtask

    task automatic run_read(input rec_t r);
        exp_t e;
        int   lat;
        sb.push_back('{data: r.exp_data, err: r.exp_err, lat: int'(r.rlen) + 1});
        bus.m_re   = 1'b1;
        bus.addr   = r.addr;
        bus.m_rlen = r.rlen;
        tick();
        check("busy_at_accept", 32'(bus.busy), 32'd1);
        check("rack_low_at_accept", 32'(bus.m_rack), 32'd0);
        // Post-accept changes must be ignored.
        bus.addr   = $urandom;
        bus.m_rlen = 2'($urandom);
        lat = 0;
        while (!bus.m_rack && lat < 12) begin
            tick();
            lat++;
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            e = '{data: 32'h0, err: 1'b0, lat: 0};
        end else begin
            e = sb.pop_front();
        end
        check("ack_latency", 32'(lat), 32'(e.lat));
        check("rdata", bus.m_rdata, e.data);
        check("rerr", 32'(bus.m_rerr), 32'(e.err));
        for (int i = 0; i < r.hold; i++) begin
            tick();
            check("hold_rack", 32'(bus.m_rack), 32'd1);
            check("hold_rdata", bus.m_rdata, e.data);
        end
        bus.m_re = 1'b0;
        tick();
        check("release_rack", 32'(bus.m_rack), 32'd0);
        check("release_busy", 32'(bus.busy), 32'd0);
        check("release_rerr", 32'(bus.m_rerr), 32'd0);
        check("release_rdata_held", bus.m_rdata, e.data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec[0] = '{addr: 32'h0000_1000, rlen: 2'd3, exp_data: 32'h0010_0513, exp_err: 1'b0, hold: 5};
        vec[1] = '{addr: 32'h0000_1001, rlen: 2'd0, exp_data: 32'h0000_0005, exp_err: 1'b0, hold: 0};
        vec[2] = '{addr: 32'h0000_1FFE, rlen: 2'd3, exp_data: 32'hDDCC_BBAA, exp_err: 1'b0, hold: 1};
        vec[3] = '{addr: 32'h0001_0000, rlen: 2'd3, exp_data: 32'h0000_0000, exp_err: 1'b1, hold: 0};
        vec[4] = '{addr: 32'h0000_1002, rlen: 2'd1, exp_data: 32'h0000_0010, exp_err: 1'b0, hold: 0};
        vec[5] = '{addr: 32'h0000_1FFF, rlen: 2'd1, exp_data: 32'h0000_CCBB, exp_err: 1'b0, hold: 2};
        vec[6] = '{addr: 32'h8000_1000, rlen: 2'd0, exp_data: 32'h0000_0000, exp_err: 1'b1, hold: 2};

        rst        = 1'b1;
        ld_we      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        bus.m_re   = 1'b0;
        bus.addr   = '0;
        bus.m_rlen = '0;
        repeat (3) tick();
        check("reset_rack", 32'(bus.m_rack), 32'd0);
        check("reset_rdata", bus.m_rdata, 32'd0);
        check("reset_rerr", 32'(bus.m_rerr), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();

        ld_byte(13'h1000, 8'h13);
        ld_byte(13'h1001, 8'h05);
        ld_byte(13'h1002, 8'h10);
        ld_byte(13'h1003, 8'h00);
        ld_byte(13'h1FFE, 8'hAA);
        ld_byte(13'h1FFF, 8'hBB);
        ld_byte(13'h0000, 8'hCC);
        ld_byte(13'h0001, 8'hDD);

        for (int i = 0; i < 7; i++) begin
            run_read(vec[i]);
        end

        // Abort after two RD edges: no acknowledge ever appears.
        bus.m_re   = 1'b1;
        bus.addr   = 32'h0000_1000;
        bus.m_rlen = 2'd3;
        tick();
        tick();
        tick();
        check("abort_busy_in_rd", 32'(bus.busy), 32'd1);
        check("abort_rack_in_rd", 32'(bus.m_rack), 32'd0);
        bus.m_re = 1'b0;
        tick();
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_rack", 32'(bus.m_rack), 32'd0);
        tick();
        tick();
        check("abort_rack_later", 32'(bus.m_rack), 32'd0);

        // Reset while acknowledging.
        bus.m_re   = 1'b1;
        bus.addr   = 32'h0000_1001;
        bus.m_rlen = 2'd0;
        tick();
        tick();
        check("rst_ack_rack_before", 32'(bus.m_rack), 32'd1);
        check("rst_ack_rdata_before", bus.m_rdata, 32'h0000_0005);
        rst = 1'b1;
        tick();
        check("rst_ack_rack", 32'(bus.m_rack), 32'd0);
        check("rst_ack_busy", 32'(bus.busy), 32'd0);
        check("rst_ack_rdata", bus.m_rdata, 32'd0);
        rst      = 1'b0;
        bus.m_re = 1'b0;
        tick();
        check("rst_ack_idle", 32'(bus.busy), 32'd0);

        // Load byte 2 on the very edge that captures it.
        bus.m_re   = 1'b1;
        bus.addr   = 32'h0000_1000;
        bus.m_rlen = 2'd3;
        tick();
        tick();
        tick();
        ld_we   = 1'b1;
        ld_addr = 13'h1002;
        ld_data = 8'h77;
        tick();
        ld_we   = 1'b0;
        tick();
        check("collide_rack", 32'(bus.m_rack), 32'd1);
        check("collide_old_byte", bus.m_rdata, 32'h0010_0513);
        bus.m_re = 1'b0;
        tick();
        run_read('{addr: 32'h0000_1000, rlen: 2'd3, exp_data: 32'h0077_0513, exp_err: 1'b0,
                   hold: 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
